demux_1x4_stream: RTL

//   Registered 1-to-4 stream demultiplexer; inverse of the team's 4x1 mux.

---
 rtl/demux_1x4_stream.sv | 128 ++++++++++++
 1 files changed

// File: rtl/demux_1x4_stream.sv
// -----------------------------------------------------------------------------
// demux_1x4_stream
//   Registered 1-to-4 valid/ready stream demultiplexer. A shared producer's
//   beats are steered to one of four consumers selected by {s1,s0}. The select
//   is sampled on a packet's first beat and held until its last beat; a select
//   change seen on a mid-packet accept is ignored and flagged on sel_err.
//
// Ports
//   clk      in   1       rising-edge clock
//   rst      in   1       asynchronous active-high reset
//   i        in   DATA_W  input data beat
//   i_valid  in   1       input beat valid
//   i_last   in   1       input beat is last of packet
//   i_ready  out  1       input beat may be accepted this cycle
//   s0, s1   in   1       channel select {s1,s0}
//   y        out  DATA_W  output data (shared by all channels)
//   y_last   out  1       output beat is last of packet
//   y_valid  out  4       per-channel valid (one-hot or zero)
//   y_ready  in   4       per-channel ready
//   sel_err  out  1       one-cycle pulse: select changed mid-packet
// -----------------------------------------------------------------------------
module demux_1x4_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              i_ready,
  input  logic              s0,
  input  logic              s1,
  output logic [DATA_W-1:0] y,
  output logic              y_last,
  output logic [3:0]        y_valid,
  input  logic [3:0]        y_ready,
  output logic              sel_err
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        held_sel_q, held_sel_d;
  logic [1:0]        ch_buf_q, ch_buf_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              y_last_q, y_last_d;
  logic [3:0]        y_valid_q, y_valid_d;
  logic              sel_err_q, sel_err_d;

  logic [1:0] sel_in;
  logic [1:0] chan;
  logic       buf_full;
  logic       out_xfer;
  logic       accept;

  assign sel_in   = {s1, s0};
  assign buf_full = |y_valid_q;
  // Only the ready of the channel holding the buffered beat can drain it.
  assign out_xfer = buf_full && y_ready[ch_buf_q];
  // No path from i_valid: ready depends on buffer state and y_ready only.
  assign i_ready  = !buf_full || y_ready[ch_buf_q];
  assign accept   = i_valid && i_ready;
  // Mid-packet beats follow the select captured on the first beat.
  assign chan     = (state_q == PKT) ? held_sel_q : sel_in;

  always_comb begin
    state_d    = state_q;
    held_sel_d = held_sel_q;
    ch_buf_d   = ch_buf_q;
    y_d        = y_q;
    y_last_d   = y_last_q;
    y_valid_d  = y_valid_q;
    sel_err_d  = 1'b0;

    if (accept) begin
      // Accept overwrites the buffer; if it was draining this cycle, there
      // is no bubble between the two beats.
      y_d       = i;
      y_last_d  = i_last;
      ch_buf_d  = chan;
      y_valid_d = 4'b0001 << chan;
    end else if (out_xfer) begin
      y_valid_d = 4'b0000;
    end

    case (state_q)
      IDLE: begin
        if (accept && !i_last) begin
          held_sel_d = sel_in;
          state_d    = PKT;
        end
      end
      PKT: begin
        if (accept) begin
          sel_err_d = (sel_in != held_sel_q);
          if (i_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      held_sel_q <= 2'b00;
      ch_buf_q   <= 2'b00;
      y_q        <= '0;
      y_last_q   <= 1'b0;
      y_valid_q  <= 4'b0000;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_sel_q <= held_sel_d;
      ch_buf_q   <= ch_buf_d;
      y_q        <= y_d;
      y_last_q   <= y_last_d;
      y_valid_q  <= y_valid_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign y       = y_q;
  assign y_last  = y_last_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;

endmodule
